// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store front end.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

  localparam int MEM_WORDS_DEFAULT = 128;

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: extracts and extends load lanes, and merges store lanes
// into a memory word for the read-modify-write path.
module byte_lane_unit import mem_pkg::*; #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] rd_word,
  input  logic [1:0]  addr_lo,
  input  size_e       lane_size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [1:0]  byte_idx;
  logic        half_idx;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Big-endian mirrors the lane numbering so address offset 0 is the top byte.
  always_comb begin
    byte_idx    = BIG_ENDIAN ? ~addr_lo : addr_lo;
    half_idx    = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
    lane_b      = rd_word[{byte_idx, 3'b000} +: 8];
    lane_h      = rd_word[{half_idx, 4'b0000} +: 16];
    load_data   = rd_word;
    merged_word = rd_word;
    case (lane_size)
      SZ_BYTE: begin
        load_data = {{24{is_signed & lane_b[7]}}, lane_b};
        merged_word[{byte_idx, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{is_signed & lane_h[15]}}, lane_h};
        merged_word[{half_idx, 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data   = rd_word;
        merged_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the unified word memory: one request at a time,
// sub-word stores via a registered read-modify-write, errors answered without memory access.
module mem_access_unit import mem_pkg::*; #(
  parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_e      state, state_next;
  size_e       req_sz, size_q;
  logic        signed_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic        accept, req_err;
  logic [31:0] lane_load, lane_merge;

  assign req_sz     = size_e'(req_size);
  assign accept     = req_valid && (state == ST_IDLE);
  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign mem_we     = (state == ST_WRITE);

  // Priority order matters only for readability; any hit yields the same error response.
  always_comb begin
    req_err = 1'b0;
    if (req_sz == SZ_RSVD)
      req_err = 1'b1;
    else if (req_sz == SZ_HALF && req_addr[0])
      req_err = 1'b1;
    else if (req_sz == SZ_WORD && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    else if (req_addr[31:2] >= WORD_LIMIT)
      req_err = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)
            state_next = ST_RESP;
          else if (!req_write)
            state_next = ST_LOAD;
          else if (req_sz == SZ_WORD)
            state_next = ST_WRITE;
          else
            state_next = ST_READ;
        end
      end
      ST_LOAD:  state_next = ST_RESP;
      ST_READ:  state_next = ST_WRITE;
      ST_WRITE: state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  byte_lane_unit #(.BIG_ENDIAN(BIG_ENDIAN)) u_lanes (
    .rd_word     (mem_rd),
    .addr_lo     (addr_lo_q),
    .lane_size   (size_q),
    .is_signed   (signed_q),
    .wdata       (wdata_q),
    .load_data   (lane_load),
    .merged_word (lane_merge)
  );

  // Response fields only change on the edge that enters RESP, so they hold between responses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_addr   <= '0;
      mem_wd     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      addr_lo_q  <= 2'b00;
      wdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mem_addr  <= {req_addr[31:2], 2'b00};
            size_q    <= req_sz;
            signed_q  <= req_signed;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && req_sz == SZ_WORD) begin
              mem_wd <= req_wdata;
            end
          end
        end
        ST_LOAD: begin
          resp_rdata <= lane_load;
          resp_err   <= 1'b0;
        end
        ST_READ: begin
          mem_wd <= lane_merge;
        end
        ST_WRITE: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table-driven requests with a scoreboard, plus reset-abort
// and big-endian sequences against behavioural word memories.
module tb_mem_access_unit;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we;
    logic [31:0] waddr;
    int          acc_cyc;
    int          idx;
  } exp_t;

  localparam int NVEC = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, be_req_valid;
  logic        req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;
  logic        be_req_ready, be_resp_valid, be_resp_err, be_mem_we;
  logic [31:0] be_resp_rdata, be_mem_addr, be_mem_wd, be_mem_rd;

  logic [31:0] mem    [0:127];
  logic [31:0] be_mem [0:127];
  logic        tb_clear, tb_wr, tb_be;
  logic [6:0]  tb_idx;
  logic [31:0] tb_data;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  logic [31:0] we_addr_seen = '0;
  int   acc_log  [0:31];
  int   resp_log [0:31];
  exp_t sb_q [$];
  vec_t vecs [NVEC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit #(.MEM_WORDS(128), .BIG_ENDIAN(1'b0)) dut (
    .CLK(clk), .RST_N(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  mem_access_unit #(.MEM_WORDS(128), .BIG_ENDIAN(1'b1)) dut_be (
    .CLK(clk), .RST_N(rst_n),
    .req_valid(be_req_valid), .req_ready(be_req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(be_resp_valid), .resp_rdata(be_resp_rdata), .resp_err(be_resp_err),
    .mem_addr(be_mem_addr), .mem_wd(be_mem_wd), .mem_we(be_mem_we), .mem_rd(be_mem_rd)
  );

  assign mem_rd    = (mem_addr[31:9] == '0) ? mem[mem_addr[8:2]] : 32'h0;
  assign be_mem_rd = (be_mem_addr[31:9] == '0) ? be_mem[be_mem_addr[8:2]] : 32'h0;

  // Memories write on the negedge while write enable is high, like the real array.
  always @(negedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 128; i++) begin
        mem[i]    <= '0;
        be_mem[i] <= '0;
      end
    end else if (tb_wr) begin
      if (tb_be) be_mem[tb_idx] <= tb_data;
      else       mem[tb_idx]    <= tb_data;
    end else begin
      if (mem_we && mem_addr[31:9] == '0)       mem[mem_addr[8:2]]       <= mem_wd;
      if (be_mem_we && be_mem_addr[31:9] == '0) be_mem[be_mem_addr[8:2]] <= be_mem_wd;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every response must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_we) begin
        we_cnt++;
        we_addr_seen = mem_addr;
      end
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          checkOutput($sformatf("v%0d_rdata", e.idx), resp_rdata, e.rdata);
          checkOutput($sformatf("v%0d_err", e.idx), {31'd0, resp_err}, {31'd0, e.err});
          checkOutput($sformatf("v%0d_latency", e.idx), cyc - e.acc_cyc + 1, e.lat);
          checkOutput($sformatf("v%0d_we_cycles", e.idx), we_cnt, e.we);
          if (e.we > 0)
            checkOutput($sformatf("v%0d_mem_addr", e.idx), we_addr_seen, e.waddr);
          resp_log[e.idx] = cyc;
        end
        we_cnt = 0;
      end
    end
  end

  task automatic preloadWord(input logic be, input logic [6:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    tb_be = be; tb_idx = idx; tb_data = data; tb_wr = 1'b1;
    @(negedge clk); #1;
    tb_wr = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input bit expect_resp, input int idx);
    bit   got;
    exp_t e;
    got = 1'b0;
    @(negedge clk);
    req_write = v.wr; req_size = v.sz; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (req_ready) begin
        @(posedge clk); #1;
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (!got) begin
      checkOutput($sformatf("v%0d_accept_timeout", idx), 32'd0, 32'd1);
      return;
    end
    acc_log[idx] = cyc;
    if (expect_resp) begin
      e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat; e.we = v.exp_we;
      e.waddr = {v.addr[31:2], 2'b00}; e.acc_cyc = cyc; e.idx = idx;
      sb_q.push_back(e);
    end
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (sb_q.size() == 0) break;
    end
    if (sb_q.size() != 0) begin
      checkOutput("drain_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic beLoad(input logic [31:0] addr, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] exp, input string name);
    bit got, seen;
    int acc;
    got = 1'b0; seen = 1'b0; acc = 0;
    @(negedge clk);
    req_write = 1'b0; req_size = sz; req_signed = sgn; req_addr = addr; be_req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (be_req_ready) begin
        @(posedge clk); #1;
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    be_req_valid = 1'b0;
    acc = cyc;
    checkOutput({name, "_accept"}, {31'd0, got}, 32'd1);
    if (got) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (be_resp_valid) begin
          seen = 1'b1;
          break;
        end
      end
      checkOutput({name, "_valid"}, {31'd0, seen}, 32'd1);
      if (seen) begin
        checkOutput({name, "_rdata"}, be_resp_rdata, exp);
        checkOutput({name, "_err"}, {31'd0, be_resp_err}, 32'd0);
        checkOutput({name, "_latency"}, cyc - acc + 1, 32'd2);
      end
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h21,  32'h0,        32'h0000007F, 1'b0, 2, 0};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h22,  32'h0,        32'hFFFFFFFF, 1'b0, 2, 0};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h22,  32'h0,        32'h000000FF, 1'b0, 2, 0};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h22,  32'h0,        32'hFFFF80FF, 1'b0, 2, 0};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        32'h000080FF, 1'b0, 2, 0};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h23,  32'h0,        32'hFFFFFF80, 1'b0, 2, 0};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h20,  32'h0,        32'h00007F01, 1'b0, 2, 0};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h21,  32'hFFFFFFAB, 32'h0,        1'b0, 3, 1};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h80FFAB01, 1'b0, 2, 0};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h24,  32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h24,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h26,  32'h1234CAFE, 32'h0,        1'b0, 3, 1};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h24,  32'h0,        32'hCAFEBEEF, 1'b0, 2, 0};
    vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h22,  32'h0,        32'h0,        1'b1, 1, 0};
    vecs[14] = '{1'b1, 2'b01, 1'b0, 32'h21,  32'h5555,     32'h0,        1'b1, 1, 0};
    vecs[15] = '{1'b0, 2'b11, 1'b0, 32'h20,  32'h0,        32'h0,        1'b1, 1, 0};
    vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h200, 32'h0,        32'h0,        1'b1, 1, 0};
    vecs[17] = '{1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678, 32'h0,        1'b1, 1, 0};
    vecs[18] = '{1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0,        32'h0BADF00D, 1'b0, 2, 0};
    vecs[19] = '{1'b0, 2'b00, 1'b0, 32'h1FF, 32'h0,        32'h0000000B, 1'b0, 2, 0};

    rst_n = 1'b0; req_valid = 1'b0; be_req_valid = 1'b0;
    req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    tb_clear = 1'b1; tb_wr = 1'b0; tb_be = 1'b0; tb_idx = '0; tb_data = '0;
    @(negedge clk); #1;
    tb_clear = 1'b0;
    preloadWord(1'b0, 7'd8,   32'h80FF7F01);
    preloadWord(1'b0, 7'd127, 32'h0BADF00D);
    preloadWord(1'b1, 7'd9,   32'h11223344);

    checkOutput("reset_req_ready",  {31'd0, req_ready},  32'd1);
    checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("reset_resp_err",   {31'd0, resp_err},   32'd0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset_mem_addr",   mem_addr,   32'd0);
    checkOutput("reset_mem_wd",     mem_wd,     32'd0);
    checkOutput("reset_mem_we",     {31'd0, mem_we}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], 1'b1, i);
    waitDrain();
    checkOutput("b2b_accept_gap", acc_log[10] - resp_log[9], 32'd2);
    checkOutput("b2b_resp_gap",   resp_log[10] - resp_log[9], 32'd3);
    checkOutput("word_0x20", mem[8], 32'h80FFAB01);
    checkOutput("word_0x24", mem[9], 32'hCAFEBEEF);

    $display("[TB] reset during WRITE");
    v = '{1'b1, 2'b00, 1'b0, 32'h20, 32'h00000055, 32'h0, 1'b0, 3, 1};
    applyStimulus(v, 1'b0, 20);
    @(posedge clk); #1;
    checkOutput("abort_we_in_write", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_we_drop",     {31'd0, mem_we}, 32'd0);
    checkOutput("abort_rdata_clear", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("abort_word_kept", mem[8], 32'h80FFAB01);
    rst_n = 1'b1;
    we_cnt = 0;
    @(negedge clk); #1;
    checkOutput("abort_ready_after", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("abort_word_final", mem[8], 32'h80FFAB01);

    $display("[TB] big-endian lanes");
    beLoad(32'h24, 2'b00, 1'b0, 32'h00000011, "be_lbu_24");
    beLoad(32'h27, 2'b00, 1'b0, 32'h00000044, "be_lbu_27");
    beLoad(32'h26, 2'b01, 1'b0, 32'h00003344, "be_lhu_26");
    beLoad(32'h24, 2'b01, 1'b1, 32'h00001122, "be_lh_24");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
